// File: rtl/multi_cycle_control.sv
// Moore sequencing controller for the multi-cycle MIPS datapath.
// Optional memory wait handshake: define MULTI_CYCLE_MEM_WAIT_EN.
module multi_cycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PC_Write,
  output logic       PC_Write_Cond,
  output logic       IorD,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       Mem_To_Reg,
  output logic       IR_Write,
  output logic       ALU_Src_A,
  output logic       Reg_Write,
  output logic       Reg_Dst,
  output logic       Branch_Not_Equal,
  output logic       ext_type,
  output logic [1:0] PC_Source,
  output logic [1:0] ALU_Src_B,
  output logic [2:0] ALU_OP,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  state_t     cur;
  state_t     nxt;
  logic [5:0] op_q;
  logic       ready;

`ifdef MULTI_CYCLE_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= S_IDLE;
      op_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE)
        op_q <= opcode;
    end
  end

  always_comb begin
    nxt              = S_IDLE;
    PC_Write         = 1'b0;
    PC_Write_Cond    = 1'b0;
    IorD             = 1'b0;
    Mem_Read         = 1'b0;
    Mem_Write        = 1'b0;
    Mem_To_Reg       = 1'b0;
    IR_Write         = 1'b0;
    ALU_Src_A        = 1'b0;
    Reg_Write        = 1'b0;
    Reg_Dst          = 1'b0;
    Branch_Not_Equal = 1'b0;
    ext_type         = 1'b0;
    PC_Source        = 2'b00;
    ALU_Src_B        = 2'b00;
    ALU_OP           = 3'b000;
    instr_done       = 1'b0;
    illegal_op       = 1'b0;
    unique case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        Mem_Read  = 1'b1;
        ALU_Src_B = 2'b01;
        IR_Write  = ready;
        PC_Write  = ready;
        nxt       = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALU_Src_B = 2'b11;
        case (opcode)
          OP_R:           nxt = S_R_EXEC;
          OP_LW, OP_SW:   nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:           nxt = S_JUMP;
          OP_ADDI, OP_ANDI,
          OP_ORI, OP_SLTI: nxt = S_I_EXEC;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        nxt       = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        Mem_Read = 1'b1;
        IorD     = 1'b1;
        nxt      = ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        Reg_Write  = 1'b1;
        Mem_To_Reg = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEM_WRITE: begin
        Mem_Write  = 1'b1;
        IorD       = 1'b1;
        instr_done = ready;
        nxt        = ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        ALU_Src_A = 1'b1;
        ALU_OP    = 3'b010;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        Reg_Write  = 1'b1;
        Reg_Dst    = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        ALU_Src_A        = 1'b1;
        ALU_OP           = 3'b001;
        PC_Write_Cond    = 1'b1;
        PC_Source        = 2'b01;
        Branch_Not_Equal = (op_q == OP_BNE);
        instr_done       = 1'b1;
        nxt              = S_FETCH;
      end
      S_JUMP: begin
        PC_Write   = 1'b1;
        PC_Source  = 2'b10;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_I_EXEC: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        unique case (1'b1)
          op_q == OP_ANDI: begin
            ALU_OP   = 3'b011;
            ext_type = 1'b1;
          end
          op_q == OP_ORI: begin
            ALU_OP   = 3'b100;
            ext_type = 1'b1;
          end
          op_q == OP_SLTI: ALU_OP = 3'b101;
          default:         ALU_OP = 3'b000;
        endcase
        nxt = S_I_WB;
      end
      S_I_WB: begin
        Reg_Write  = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed, table-driven bench for multi_cycle_control.
// Wait-state sequences depend on MULTI_CYCLE_MEM_WAIT_EN.
module tb_multi_cycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write;
  logic       Mem_To_Reg, IR_Write, ALU_Src_A, Reg_Write, Reg_Dst;
  logic       Branch_Not_Equal, ext_type, instr_done, illegal_op;
  logic [1:0] PC_Source, ALU_Src_B;
  logic [2:0] ALU_OP;
  logic [3:0] state;

  multi_cycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .IorD(IorD),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_To_Reg(Mem_To_Reg),
    .IR_Write(IR_Write), .ALU_Src_A(ALU_Src_A), .Reg_Write(Reg_Write),
    .Reg_Dst(Reg_Dst), .Branch_Not_Equal(Branch_Not_Equal),
    .ext_type(ext_type), .PC_Source(PC_Source), .ALU_Src_B(ALU_Src_B),
    .ALU_OP(ALU_OP), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [20:0] PCW  = 21'd1 << 20;
  localparam logic [20:0] PCWC = 21'd1 << 19;
  localparam logic [20:0] IORD = 21'd1 << 18;
  localparam logic [20:0] MR   = 21'd1 << 17;
  localparam logic [20:0] MW   = 21'd1 << 16;
  localparam logic [20:0] M2R  = 21'd1 << 15;
  localparam logic [20:0] IRW  = 21'd1 << 14;
  localparam logic [20:0] SA   = 21'd1 << 13;
  localparam logic [20:0] RW   = 21'd1 << 12;
  localparam logic [20:0] RDST = 21'd1 << 11;
  localparam logic [20:0] BNE  = 21'd1 << 10;
  localparam logic [20:0] EXT  = 21'd1 << 9;
  localparam logic [20:0] PS_A = 21'd1 << 7;
  localparam logic [20:0] PS_J = 21'd2 << 7;
  localparam logic [20:0] SB_4 = 21'd1 << 5;
  localparam logic [20:0] SB_I = 21'd2 << 5;
  localparam logic [20:0] SB_S = 21'd3 << 5;
  localparam logic [20:0] A_SUB = 21'd1 << 2;
  localparam logic [20:0] A_R   = 21'd2 << 2;
  localparam logic [20:0] A_AND = 21'd3 << 2;
  localparam logic [20:0] A_OR  = 21'd4 << 2;
  localparam logic [20:0] A_SLT = 21'd5 << 2;
  localparam logic [20:0] DONE = 21'd2;
  localparam logic [20:0] ILL  = 21'd1;
  localparam logic [20:0] F    = PCW | MR | IRW | SB_4;
  localparam logic [20:0] D    = SB_S;

  logic [20:0] act;
  assign act = {PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write,
                Mem_To_Reg, IR_Write, ALU_Src_A, Reg_Write, Reg_Dst,
                Branch_Not_Equal, ext_type, PC_Source, ALU_Src_B,
                ALU_OP, instr_done, illegal_op};

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [20:0] ex;
  } vec_t;

  vec_t tbl[80];
  int   n;
  int   compared;
  int   mismatched;
  int   done_cnt;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp,
               $time);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [3:0] st,
                     input logic [20:0] ex);
    tbl[n] = '{op: op, rdy: 1'b1, st: st, ex: ex};
    n++;
  endtask

  task automatic step(input string name, input logic [5:0] op,
                      input logic rdy, input logic [3:0] st,
                      input logic [20:0] ex);
    opcode    = op;
    mem_ready = rdy;
    #1;
    check({name, ".state"}, {28'd0, state}, {28'd0, st});
    check({name, ".ctl"}, {11'd0, act}, {11'd0, ex});
    if (instr_done === 1'b1) done_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("reset.state", {28'd0, state}, 32'd0);
    check("reset.ctl", {11'd0, act}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    done_cnt   = 0;
    n          = 0;
    opcode     = 6'h00;
    mem_ready  = 1'b1;
    rst_n      = 1'b0;

    add(6'h23, 4'd0,  '0);
    add(6'h23, 4'd1,  F);
    add(6'h23, 4'd2,  D);
    add(6'h2B, 4'd3,  SA | SB_I);
    add(6'h2B, 4'd4,  MR | IORD);
    add(6'h2B, 4'd5,  RW | M2R | DONE);
    add(6'h00, 4'd1,  F);
    add(6'h00, 4'd2,  D);
    add(6'h00, 4'd7,  SA | A_R);
    add(6'h00, 4'd8,  RW | RDST | DONE);
    add(6'h05, 4'd1,  F);
    add(6'h05, 4'd2,  D);
    add(6'h04, 4'd9,  SA | A_SUB | PCWC | PS_A | BNE | DONE);
    add(6'h04, 4'd1,  F);
    add(6'h04, 4'd2,  D);
    add(6'h05, 4'd9,  SA | A_SUB | PCWC | PS_A | DONE);
    add(6'h0D, 4'd1,  F);
    add(6'h0D, 4'd2,  D);
    add(6'h0D, 4'd11, SA | SB_I | A_OR | EXT);
    add(6'h0D, 4'd12, RW | DONE);
    add(6'h0C, 4'd1,  F);
    add(6'h0C, 4'd2,  D);
    add(6'h08, 4'd11, SA | SB_I | A_AND | EXT);
    add(6'h08, 4'd12, RW | DONE);
    add(6'h0A, 4'd1,  F);
    add(6'h0A, 4'd2,  D);
    add(6'h0A, 4'd11, SA | SB_I | A_SLT);
    add(6'h0A, 4'd12, RW | DONE);
    add(6'h08, 4'd1,  F);
    add(6'h08, 4'd2,  D);
    add(6'h0D, 4'd11, SA | SB_I);
    add(6'h0D, 4'd12, RW | DONE);
    add(6'h02, 4'd1,  F);
    add(6'h02, 4'd2,  D);
    add(6'h02, 4'd10, PCW | PS_J | DONE);
    add(6'h2B, 4'd1,  F);
    add(6'h2B, 4'd2,  D);
    add(6'h23, 4'd3,  SA | SB_I);
    add(6'h23, 4'd6,  MW | IORD | DONE);
    add(6'h3F, 4'd1,  F);
    add(6'h3F, 4'd2,  D | ILL);
    add(6'h00, 4'd1,  F);

    do_reset();
    for (int i = 0; i < n; i++)
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].rdy, tbl[i].st,
           tbl[i].ex);
    check("instr_done_count", done_cnt, 32'd10);

`ifdef MULTI_CYCLE_MEM_WAIT_EN
    do_reset();
    step("sw.idle", 6'h2B, 1'b1, 4'd0, '0);
    step("sw.fw0", 6'h2B, 1'b0, 4'd1, MR | SB_4);
    step("sw.fw1", 6'h2B, 1'b0, 4'd1, MR | SB_4);
    step("sw.f", 6'h2B, 1'b1, 4'd1, F);
    step("sw.dec", 6'h2B, 1'b1, 4'd2, D);
    step("sw.addr", 6'h00, 1'b1, 4'd3, SA | SB_I);
    step("sw.w0", 6'h00, 1'b0, 4'd6, MW | IORD);
    step("sw.w1", 6'h00, 1'b0, 4'd6, MW | IORD);
    step("sw.w2", 6'h00, 1'b0, 4'd6, MW | IORD);
    step("sw.w3", 6'h00, 1'b1, 4'd6, MW | IORD | DONE);
    step("sw.next", 6'h23, 1'b1, 4'd1, F);
    step("lw.dec", 6'h23, 1'b1, 4'd2, D);
    step("lw.addr", 6'h23, 1'b1, 4'd3, SA | SB_I);
    step("lw.r0", 6'h23, 1'b0, 4'd4, MR | IORD);
    step("lw.r1", 6'h23, 1'b1, 4'd4, MR | IORD);
    step("lw.wb", 6'h23, 1'b1, 4'd5, RW | M2R | DONE);
    step("sw2.f", 6'h2B, 1'b1, 4'd1, F);
    step("sw2.dec", 6'h2B, 1'b1, 4'd2, D);
    step("sw2.addr", 6'h2B, 1'b0, 4'd3, SA | SB_I);
    mem_ready = 1'b0;
    #1;
    check("sw2.wait", {28'd0, state}, 32'd6);
`else
    do_reset();
    step("sw.idle", 6'h2B, 1'b0, 4'd0, '0);
    step("sw.f", 6'h2B, 1'b0, 4'd1, F);
    step("sw.dec", 6'h2B, 1'b0, 4'd2, D);
    step("sw.addr", 6'h00, 1'b0, 4'd3, SA | SB_I);
    step("sw.w", 6'h00, 1'b0, 4'd6, MW | IORD | DONE);
    step("lw.f", 6'h23, 1'b0, 4'd1, F);
    step("lw.dec", 6'h23, 1'b0, 4'd2, D);
    step("lw.addr", 6'h23, 1'b0, 4'd3, SA | SB_I);
    mem_ready = 1'b0;
    #1;
    check("lw.read", {28'd0, state}, 32'd4);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst.state", {28'd0, state}, 32'd0);
    check("async_rst.ctl", {11'd0, act}, 32'd0);
    @(negedge clk);
    #1;
    check("rst_hold.state", {28'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
